// File: rtl/ula_seq_ctrl.sv
// ula_seq_ctrl: sequencing controller for a small ULA datapath made of an
// X register, a Y register and an arithmetic/logic unit (the ULA).
//
// The block accepts one command at a time and drives the register and ULA
// control lines for that command. MUL is carried out as a clear of Y followed
// by 'rep' ADD cycles.
//
// Optional feature: define ULA_SEQ_CTRL_OVF_EN to build the sticky overflow
// flag. Without the macro, ovf is tied to 0 and carry is ignored.
//
// Ports:
//   clock     - system clock; all state changes on its rising edge
//   resetn    - asynchronous active-low reset
//   start     - command request, sampled only while idle
//   op[2:0]   - command: CLR, LDX, ADD, SUB, AND, OR, SHY, MUL
//   rep       - MUL iteration count, captured together with start
//   carry     - carry/borrow out of the current ULA operation
//   Tx[1:0]   - X register control: 0 CLEAR, 1 LOAD, 2 HOLD, 3 DIV
//   Ty[1:0]   - Y register control, same encoding as Tx
//   sel[2:0]  - ULA function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASS
//   busy      - high whenever the controller is not idle
//   done      - one-cycle completion pulse
//   ovf       - sticky overflow flag (0 unless ULA_SEQ_CTRL_OVF_EN)
//   fsm_state - current FSM state, for debug and checkers
//
// Handshake: start is a request that is taken in the single cycle the FSM is
// idle; op and rep are captured on that same edge, and any later change to
// start, op or rep has no effect until done has pulsed and the FSM is idle
// again. There is no backpressure; done is a one-cycle pulse.
module ula_seq_ctrl #(
  parameter int REP_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [REP_W-1:0] rep,
  input  logic             carry,
  output logic [1:0]       Tx,
  output logic [1:0]       Ty,
  output logic [2:0]       sel,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_MUL_CLR = 3'd2,
    S_MUL_ADD = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_LDX = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SHY = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] T_CLEAR = 2'd0;
  localparam logic [1:0] T_LOAD  = 2'd1;
  localparam logic [1:0] T_HOLD  = 2'd2;
  localparam logic [1:0] T_DIV   = 2'd3;

  state_t           state;
  state_t           nxt;
  logic [2:0]       op_q;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] cnt;
  logic [2:0]       cmd_op;
  logic [1:0]       tx_n;
  logic [1:0]       ty_n;
  logic [2:0]       sel_n;

  // While idle the command has not been latched yet, so the EXEC outputs
  // registered on the accepting edge must come from the live op input.
  assign cmd_op    = (state == S_IDLE) ? op : op_q;
  assign fsm_state = state;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (start) nxt = (op == OP_MUL) ? S_MUL_CLR : S_EXEC;
      S_EXEC:    nxt = S_DONE;
      S_MUL_CLR: nxt = (rep_q != '0) ? S_MUL_ADD : S_DONE;
      // cnt holds the number of ADD cycles still to run, this one included.
      S_MUL_ADD: nxt = (cnt <= REP_W'(1)) ? S_DONE : S_MUL_ADD;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Control values for the cycle about to start; registered below.
  always_comb begin
    tx_n  = T_HOLD;
    ty_n  = T_HOLD;
    sel_n = 3'b000;
    unique case (nxt)
      S_EXEC: begin
        unique case (cmd_op)
          OP_CLR: begin tx_n = T_CLEAR; ty_n = T_CLEAR; end
          OP_LDX: begin tx_n = T_LOAD;  sel_n = 3'b100; end
          OP_ADD: begin ty_n = T_LOAD;  sel_n = 3'b000; end
          OP_SUB: begin ty_n = T_LOAD;  sel_n = 3'b001; end
          OP_AND: begin ty_n = T_LOAD;  sel_n = 3'b010; end
          OP_OR:  begin ty_n = T_LOAD;  sel_n = 3'b011; end
          OP_SHY: begin ty_n = T_DIV; end
          default: begin end
        endcase
      end
      S_MUL_CLR: ty_n = T_CLEAR;
      S_MUL_ADD: begin ty_n = T_LOAD; sel_n = 3'b000; end
      default:   begin end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      op_q  <= '0;
      rep_q <= '0;
      cnt   <= '0;
      Tx    <= T_HOLD;
      Ty    <= T_HOLD;
      sel   <= 3'b000;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        op_q  <= op;
        rep_q <= rep;
      end
      if (state == S_MUL_CLR) cnt <= rep_q;
      else if (state == S_MUL_ADD) cnt <= cnt - REP_W'(1);
      Tx   <= tx_n;
      Ty   <= ty_n;
      sel  <= sel_n;
      busy <= (nxt != S_IDLE);
      done <= (nxt == S_DONE);
    end
  end

`ifdef ULA_SEQ_CTRL_OVF_EN
  // Sticky: set by a carry during any ADD/SUB into Y, cleared only by the
  // CLR command's execute cycle (the only cycle with Tx and Ty both CLEAR).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovf <= 1'b0;
    end else if (Tx == T_CLEAR && Ty == T_CLEAR) begin
      ovf <= 1'b0;
    end else if (carry && Ty == T_LOAD && (sel == 3'b000 || sel == 3'b001)) begin
      ovf <= 1'b1;
    end
  end
`else
  logic unused_carry;
  assign unused_carry = carry;
  assign ovf = 1'b0;
`endif

endmodule
